uart_mem_host: RTL and testbench
================================

UART_MEM_HOST -- requirements
Module: uart_mem_host

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, meaning clk100 cycles per UART bit (115200 baud at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000, meaning the maximum number of cycles to wait for a read response.
REQ-003 SHALL have port clk100, input, 1 bit: the only clock, 100 MHz.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: ready to accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, 6 bits: word address.
REQ-009 SHALL have port req_wdata, input, 16 bits: write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 16 bits: read data.
REQ-012 SHALL have port rsp_err, output, 1 bit: error flag, qualified by rsp_valid.
REQ-013 SHALL have port UartTx, output, 1 bit: serial line to the memory device.
REQ-014 SHALL have port UartRx, input, 1 bit: serial line from the memory device, asynchronous.

Function
REQ-015 SHALL accept a request when req_valid && req_ready in IDLE, latching req_write, req_addr and req_wdata; req_ready SHALL be high only in IDLE.
REQ-016 SHALL build the command byte as {1'b0, req_write, req_addr}.
REQ-017 SHALL send three bytes, in order: cmd, data[15:8], data[7:0]; data SHALL be req_wdata for writes and 16'h0000 for reads.
REQ-018 SHALL frame each byte on UartTx as 8N1, LSB first, each bit CLK_PER_BIT cycles; bytes SHALL be back-to-back with no idle gap; UartTx SHALL idle high.
REQ-019 SHALL use the FSM IDLE -> SEND -> (write: DONE | read: WAIT_RSP -> DONE) -> IDLE.
REQ-020 SHALL, for a write, enter DONE in the cycle after the third stop bit completes; DONE SHALL pulse rsp_valid=1 with rsp_err=0 and rsp_rdata=0.
REQ-021 SHALL, for a read, receive three bytes in WAIT_RSP: echoed cmd, rdata[15:8], rdata[7:0].
REQ-022 SHALL pass UartRx through a 2-FF synchronizer, detect a falling edge as start, and sample at mid-bit (CLK_PER_BIT/2).
REQ-023 SHALL discard a start bit that reads high at its mid-bit sample as a glitch.
REQ-024 SHALL set a sticky error flag if a stop bit samples 0 (framing error); reception SHALL continue.
REQ-025 SHALL set the error flag if the echoed cmd byte differs from the sent cmd byte.
REQ-026 SHALL enter DONE on receipt of the third byte, with rsp_rdata = the received word and rsp_err = error flag.
REQ-027 SHALL start the timeout counter on entry to WAIT_RSP and never reset it on byte arrival; at TIMEOUT_CYCLES it SHALL go to DONE with rsp_err=1 and rsp_rdata=0.
REQ-028 SHALL ignore RX activity in IDLE, SEND and DONE, and SHALL abandon any byte partially received at exit from WAIT_RSP.
REQ-029 SHALL hold rsp_rdata stable until the next DONE; rsp_valid SHALL be high exactly 1 cycle per accepted request.
REQ-030 SHALL ignore req_valid while not in IDLE; a request SHALL never be queued.

Reset
REQ-031 SHALL, on rst, enter IDLE immediately (asynchronously) with UartTx=1, req_ready=1 (after the first clock), rsp_valid=0, rsp_err=0, rsp_rdata=0, all counters 0, and the error flag cleared.
REQ-032 SHALL, on rst mid-frame, abort the frame; the line SHALL return high; no rsp_valid SHALL be produced for the aborted request.

Structure
REQ-033 SHALL place in a shared package the FSM state encoding, the command bit positions (WRITE_BIT=6, ADDR_MSB=5), and the default CLK_PER_BIT; the same package SHALL be used by the memory-side UART block.
REQ-034 SHALL implement the transmit serializer as one sub-module, uart_tx_byte (inputs: start and byte; outputs: busy/done and line); the RX sampler SHALL be inline.

Verification
REQ-035 SHALL cover: write addr 0, data 0x0005 -> UartTx carries 0x40, 0x00, 0x05; rsp_valid with rsp_err=0 in the cycle after the third stop bit.
REQ-036 SHALL cover: read addr 2 with the device model replying 0x02, 0x55, 0x55 -> TX bytes 0x02, 0x00, 0x00; rsp_rdata=0x5555, rsp_err=0.
REQ-037 SHALL cover: read addr 2 with the device echoing 0x03 -> rsp_err=1, rsp_rdata=value received.
REQ-038 SHALL cover: read with no reply and TIMEOUT_CYCLES=1000 -> rsp_valid exactly 1000 cycles after WAIT_RSP entry, rsp_err=1, rsp_rdata=0.
REQ-039 SHALL cover: reply with a stop bit of 0 on byte 2 -> rsp_err=1; a 200 ns low glitch on UartRx in WAIT_RSP -> ignored and the result is correct.
REQ-040 SHALL cover: rst asserted during the second TX byte -> UartTx=1 at once, no rsp_valid, and the next write completes normally.

Source files
------------

// File: rtl/uart_mem_host_pkg.sv
// Shared definitions for the UART memory host and the memory-side UART block:
// FSM encoding, command byte layout and default bit timing.
package uart_mem_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int WRITE_BIT           = 6;
    localparam int ADDR_MSB            = 5;
    localparam int CLK_PER_BIT_DEFAULT = 868;

    function automatic logic [7:0] make_cmd(input logic wr, input logic [ADDR_MSB:0] addr);
        logic [7:0] c;
        c            = '0;
        c[WRITE_BIT] = wr;
        c[ADDR_MSB:0] = addr;
        return c;
    endfunction

endpackage

// File: rtl/uart_mem_host_tx.sv
// 8N1 byte serializer. done pulses in the last cycle of the stop bit so a
// start issued in that same cycle follows with no idle gap on the line.
module uart_tx_byte
    import uart_mem_host_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
    input  logic       clk100,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic       line
);
    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    frame_q, frame_d;
    logic          busy_q, busy_d;

    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        busy_d  = busy_q;
        done    = 1'b0;
        if (busy_q) begin
            if (cnt_q == '0) begin
                cnt_d = CW'(CLK_PER_BIT - 1);
                if (bit_q == 4'd9) begin
                    done   = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    frame_d = {1'b1, frame_q[9:1]};
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (start && (!busy_q || done)) begin
            busy_d  = 1'b1;
            bit_d   = 4'd0;
            cnt_d   = CW'(CLK_PER_BIT - 1);
            frame_d = {1'b1, tx_byte, 1'b0};
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign line = busy_q ? frame_q[0] : 1'b1;

endmodule

// File: rtl/uart_mem_host.sv
// Host side of a UART-attached word memory: sends cmd/data bytes, collects
// the three-byte read reply with echo, framing and timeout error checking.
module uart_mem_host
    import uart_mem_host_pkg::*;
#(
    parameter int CLK_PER_BIT    = CLK_PER_BIT_DEFAULT,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [5:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        UartTx,
    input  logic        UartRx
);
    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic          err_q, err_d;
    logic [7:0]    rdata_hi_q, rdata_hi_d;
    logic [15:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [2:0]    rx_sync_q;
    logic          rx_busy_q, rx_busy_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;

    logic       tx_start, tx_busy, tx_done, byte_valid;
    logic [7:0] tx_byte;

    uart_tx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
        .clk100  (clk100),
        .rst     (rst),
        .start   (tx_start),
        .tx_byte (tx_byte),
        .busy    (tx_busy),
        .done    (tx_done),
        .line    (UartTx)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        byte_cnt_d  = byte_cnt_q;
        err_d       = err_q;
        rdata_hi_d  = rdata_hi_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        to_cnt_d    = to_cnt_q;
        rx_busy_d   = rx_busy_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        tx_start    = 1'b0;
        tx_byte     = 8'h00;
        byte_valid  = 1'b0;

        // Receiver runs only while a reply is expected; leaving WAIT_RSP drops any partial byte.
        if (state_q != ST_WAIT_RSP) begin
            rx_busy_d = 1'b0;
        end else if (rx_busy_q) begin
            if (rx_cnt_q == '0) begin
                rx_cnt_d = CW'(CLK_PER_BIT - 1);
                rx_bit_d = rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_sync_q[1]) rx_busy_d = 1'b0;
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_d  = 1'b0;
                    byte_valid = 1'b1;
                    if (!rx_sync_q[1]) err_d = 1'b1;
                end else begin
                    rx_shift_d = {rx_sync_q[1], rx_shift_q[7:1]};
                end
            end else begin
                rx_cnt_d = rx_cnt_q - 1'b1;
            end
        end else if (rx_sync_q[2] && !rx_sync_q[1]) begin
            rx_busy_d = 1'b1;
            rx_bit_d  = 4'd0;
            rx_cnt_d  = CW'(CLK_PER_BIT / 2 - 1);
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d    = ST_SEND;
                    cmd_d      = make_cmd(req_write, req_addr);
                    wdata_d    = req_write ? req_wdata : 16'h0000;
                    write_d    = req_write;
                    byte_cnt_d = 2'd0;
                    err_d      = 1'b0;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tx_byte  = cmd_q;
                end else if (tx_done) begin
                    if (byte_cnt_q == 2'd2) begin
                        byte_cnt_d = 2'd0;
                        to_cnt_d   = TW'(TIMEOUT_CYCLES - 1);
                        if (write_q) begin
                            state_d     = ST_DONE;
                            rsp_rdata_d = 16'h0000;
                            rsp_err_d   = 1'b0;
                        end else begin
                            state_d = ST_WAIT_RSP;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_start   = 1'b1;
                        tx_byte    = (byte_cnt_q == 2'd0) ? wdata_q[15:8] : wdata_q[7:0];
                    end
                end
            end
            ST_WAIT_RSP: begin
                to_cnt_d = to_cnt_q - 1'b1;
                if (byte_valid && byte_cnt_q == 2'd0) begin
                    byte_cnt_d = 2'd1;
                    if (rx_shift_q != cmd_q) err_d = 1'b1;
                end
                if (byte_valid && byte_cnt_q == 2'd1) begin
                    byte_cnt_d = 2'd2;
                    rdata_hi_d = rx_shift_q;
                end
                if (byte_valid && byte_cnt_q == 2'd2) begin
                    state_d     = ST_DONE;
                    rsp_rdata_d = {rdata_hi_q, rx_shift_q};
                    rsp_err_d   = err_d;
                end else if (to_cnt_q == '0) begin
                    state_d     = ST_DONE;
                    rsp_rdata_d = 16'h0000;
                    rsp_err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            byte_cnt_q  <= '0;
            err_q       <= 1'b0;
            rdata_hi_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            to_cnt_q    <= '0;
            rx_sync_q   <= '1;
            rx_busy_q   <= 1'b0;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            byte_cnt_q  <= byte_cnt_d;
            err_q       <= err_d;
            rdata_hi_q  <= rdata_hi_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            to_cnt_q    <= to_cnt_d;
            rx_sync_q   <= {rx_sync_q[1:0], UartRx};
            rx_busy_q   <= rx_busy_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_mem_host.sv
// Directed bench for uart_mem_host: TX line decoder, device reply driver and a
// response model checked every cycle against two DUT instances.
module tb_uart_mem_host;
    localparam int CPB      = 64;
    localparam int TO_MAIN  = 6000;
    localparam int TO_SHORT = 1000;

    logic        clk100 = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_valid_to = 1'b0, req_write = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        UartRx = 1'b1;
    logic        req_ready, rsp_valid, rsp_err, UartTx;
    logic [15:0] rsp_rdata;
    logic        req_ready_to, rsp_valid_to, rsp_err_to, UartTx_to;
    logic [15:0] rsp_rdata_to;

    uart_mem_host #(.CLK_PER_BIT(CPB), .TIMEOUT_CYCLES(TO_MAIN)) dut (
        .clk100(clk100), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .UartTx(UartTx), .UartRx(UartRx));

    uart_mem_host #(.CLK_PER_BIT(CPB), .TIMEOUT_CYCLES(TO_SHORT)) dut_to (
        .clk100(clk100), .rst(rst), .req_valid(req_valid_to), .req_ready(req_ready_to),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_to), .rsp_rdata(rsp_rdata_to), .rsp_err(rsp_err_to),
        .UartTx(UartTx_to), .UartRx(1'b1));

    always #5 clk100 = ~clk100;

    int cyc = 0;
    always @(posedge clk100) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Selected instance for TX decoding and response comparison.
    logic mon_sel = 1'b0;
    wire        mon_line = mon_sel ? UartTx_to    : UartTx;
    wire        m_valid  = mon_sel ? rsp_valid_to : rsp_valid;
    wire        m_ready  = mon_sel ? req_ready_to : req_ready;
    wire        m_err    = mon_sel ? rsp_err_to   : rsp_err;
    wire [15:0] m_rdata  = mon_sel ? rsp_rdata_to : rsp_rdata;
    wire        o_valid  = mon_sel ? rsp_valid    : rsp_valid_to;

    logic [7:0] tx_q[$];
    int         tx_t[$];
    logic       tx_stop_q[$];

    initial begin : tx_mon
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk100);
            if (mon_line === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk100);
                if (mon_line === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk100);
                        b[i] = mon_line;
                    end
                    repeat (CPB) @(negedge clk100);
                    tx_q.push_back(b);
                    tx_t.push_back(t0);
                    tx_stop_q.push_back(mon_line);
                end
            end
        end
    end

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t        exp_q[$];
    logic        m_busy = 1'b0;
    int          rsp_count = 0;
    logic [15:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always @(negedge clk100) begin : compare
        exp_t e;
        if (!rst) chk("req_ready", m_ready, !m_busy);
        chk("rsp_other_instance", o_valid, 0);
        if (m_valid) begin
            rsp_count++;
            last_rdata = m_rdata;
            last_err   = m_err;
            chk("rsp_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", m_rdata, e.rdata);
                chk("rsp_err", m_err, e.err);
                if (e.cyc >= 0) chk("rsp_cycle", cyc, e.cyc);
            end
            m_busy = 1'b0;
        end
    end

    task automatic do_req(input logic sel, input logic w, input logic [5:0] a, input logic [15:0] d);
        @(negedge clk100); #1;
        req_write = w; req_addr = a; req_wdata = d; m_busy = 1'b1;
        if (sel) req_valid_to = 1'b1; else req_valid = 1'b1;
        @(negedge clk100); #1;
        req_valid = 1'b0; req_valid_to = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 40 * CPB && tx_q.size() < n; i++) @(negedge clk100);
        chk("tx_bytes_seen", tx_q.size() >= n, 1);
    endtask

    task automatic wait_rsp(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk100);
        chk("rsp_arrived", exp_q.size(), 0);
    endtask

    // Expected frame: cmd = {0, write, addr}, then data (zero for reads), back-to-back.
    task automatic check_tx(input logic w, input logic [5:0] a, input logic [15:0] d);
        logic [7:0] c;
        logic [15:0] dd;
        c  = {1'b0, w, a};
        dd = w ? d : 16'h0000;
        if (tx_q.size() >= 3) begin
            chk("tx_cmd", tx_q[0], c);
            chk("tx_hi", tx_q[1], dd[15:8]);
            chk("tx_lo", tx_q[2], dd[7:0]);
            chk("tx_stops", {tx_stop_q[0], tx_stop_q[1], tx_stop_q[2]}, 3'b111);
            chk("tx_gap1", tx_t[1] - tx_t[0], 10 * CPB);
            chk("tx_gap2", tx_t[2] - tx_t[0], 20 * CPB);
        end
    endtask

    task automatic send_rx_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UartRx = f[i];
            repeat (CPB) @(posedge clk100);
        end
        UartRx = 1'b1;
        repeat (CPB) @(posedge clk100);
    endtask

    task automatic run_write(input logic [5:0] a, input logic [15:0] d);
        exp_t e;
        tx_q.delete(); tx_t.delete(); tx_stop_q.delete();
        do_req(1'b0, 1'b1, a, d);
        wait_tx(3);
        check_tx(1'b1, a, d);
        e.rdata = 16'h0000; e.err = 1'b0;
        e.cyc = (tx_t.size() > 0) ? tx_t[0] + 30 * CPB : -1;
        exp_q.push_back(e);
        wait_rsp(4 * CPB);
    endtask

    task automatic run_read(input logic [5:0] a, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [2:0] stops, input logic glitch,
                            input logic stray);
        exp_t e;
        tx_q.delete(); tx_t.delete(); tx_stop_q.delete();
        do_req(1'b0, 1'b0, a, 16'hFFFF);
        if (stray) begin
            repeat (50) @(negedge clk100); #1;
            req_write = 1'b1; req_addr = 6'h11; req_wdata = 16'h7777; req_valid = 1'b1;
            @(negedge clk100); #1;
            req_valid = 1'b0;
        end
        wait_tx(3);
        check_tx(1'b0, a, 16'h0000);
        e.rdata = {b1, b2};
        e.err   = (b0 != {2'b00, a}) || (stops != 3'b111);
        e.cyc   = -1;
        exp_q.push_back(e);
        repeat (2 * CPB) @(posedge clk100);
        if (glitch) begin
            UartRx = 1'b0;
            repeat (20) @(posedge clk100);
            UartRx = 1'b1;
            repeat (2 * CPB) @(posedge clk100);
        end
        send_rx_byte(b0, stops[0]);
        send_rx_byte(b1, stops[1]);
        send_rx_byte(b2, stops[2]);
        wait_rsp(4 * CPB);
    endtask

    initial begin : main
        int cnt_before;
        exp_t e;
        #1 rst = 1'b1;
        #1;
        chk("rst_uarttx", UartTx, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        repeat (3) @(negedge clk100);
        #1 rst = 1'b0;
        @(negedge clk100);
        chk("rst_req_ready", req_ready, 1);

        run_write(6'h00, 16'h0005);
        if (tx_q.size() >= 3) begin
            chk("lit_w_cmd", tx_q[0], 8'h40);
            chk("lit_w_hi", tx_q[1], 8'h00);
            chk("lit_w_lo", tx_q[2], 8'h05);
        end

        run_read(6'h02, 8'h02, 8'h55, 8'h55, 3'b111, 1'b0, 1'b1);
        chk("lit_r_rdata", last_rdata, 16'h5555);
        chk("lit_r_err", last_err, 0);
        if (tx_q.size() >= 1) chk("lit_r_cmd", tx_q[0], 8'h02);

        run_read(6'h02, 8'h03, 8'hBE, 8'hEF, 3'b111, 1'b0, 1'b0);
        chk("lit_echo_err", last_err, 1);
        chk("lit_echo_rdata", last_rdata, 16'hBEEF);

        run_read(6'h02, 8'h02, 8'h55, 8'hAA, 3'b101, 1'b0, 1'b0);
        chk("lit_frame_err", last_err, 1);

        run_read(6'h02, 8'h02, 8'h12, 8'h34, 3'b111, 1'b1, 1'b0);
        chk("lit_glitch_rdata", last_rdata, 16'h1234);

        mon_sel = 1'b1;
        tx_q.delete(); tx_t.delete(); tx_stop_q.delete();
        do_req(1'b1, 1'b0, 6'h3F, 16'h0000);
        wait_tx(3);
        check_tx(1'b0, 6'h3F, 16'h0000);
        e.rdata = 16'h0000; e.err = 1'b1;
        e.cyc = (tx_t.size() > 0) ? tx_t[0] + 30 * CPB + TO_SHORT : -1;
        exp_q.push_back(e);
        wait_rsp(TO_SHORT + 4 * CPB);
        @(negedge clk100);
        mon_sel = 1'b0;

        tx_q.delete(); tx_t.delete(); tx_stop_q.delete();
        cnt_before = rsp_count;
        do_req(1'b0, 1'b1, 6'h15, 16'hABCD);
        wait_tx(1);
        if (tx_t.size() > 0)
            for (int i = 0; i < 20 * CPB && cyc < tx_t[0] + 10 * CPB + 5; i++) @(negedge clk100);
        chk("abort_tx_low", UartTx, 0);
        #1 rst = 1'b1;
        #1;
        chk("abort_tx_idle", UartTx, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rdata_clr", rsp_rdata, 0);
        m_busy = 1'b0;
        repeat (3) @(negedge clk100);
        #1 rst = 1'b0;
        repeat (12 * CPB) @(negedge clk100);
        chk("abort_no_rsp", rsp_count, cnt_before);
        run_write(6'h2A, 16'h1234);

        chk("exp_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
